// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, access
// size codes, bus widths and the latched request payload.
`timescale 1ns/1ps
package lsu_pkg;

  localparam int unsigned WORD_AW = 16;
  localparam int unsigned BYTE_AW = 18;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANE_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WT   = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef struct packed {
    logic                 write;
    size_e                size;
    logic                 is_signed;
    logic [BYTE_AW-1:0]   addr;
    logic [DATA_W-1:0]    wdata;
  } req_t;

  // Reserved size code is always treated as misaligned.
  function automatic logic misaligned(input size_e size, input logic [LANE_W-1:0] lane);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lane[0];
      SZ_WORD: misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake bundle between the execute stage (master) and
// the load/store unit (slave).
`timescale 1ns/1ps
interface load_store_unit_if;
  import lsu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [BYTE_AW-1:0]  req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extract/extend a sub-word for loads and merge
// store data into the addressed lane for read-modify-write.
`timescale 1ns/1ps
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  size_e             size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic [DATA_W-1:0] merged_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = word[{lane, 3'b000} +: 8];
    half_v   = word[{lane[1], 4'b0000} +: 16];
    rdata_c  = word;
    merged_c = word;
    case (size)
      SZ_BYTE: begin
        rdata_c = {{24{is_signed & byte_v[7]}}, byte_v};
        merged_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata_c = {{16{is_signed & half_v[15]}}, half_v};
        merged_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        rdata_c  = word;
        merged_c = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed load/store requests mapped onto a
// word-wide memory with a one-cycle registered read port.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output logic               mem_write,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_datain,
  input  logic [DATA_W-1:0]  mem_dataout
);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                mem_write_q, mem_write_d;
  logic [WORD_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_datain_q, mem_datain_d;

  logic [DATA_W-1:0]   lane_rdata_c;
  logic [DATA_W-1:0]   lane_merged_c;
  size_e               in_size_c;

  assign in_size_c = size_e'(bus.req_size);

  lsu_lane u_lane (
    .word      (mem_dataout),
    .lane      (req_q.addr[LANE_W-1:0]),
    .size      (req_q.size),
    .is_signed (req_q.is_signed),
    .wdata     (req_q.wdata),
    .rdata_c   (lane_rdata_c),
    .merged_c  (lane_merged_c)
  );

  // Next-state and next-output computation; all outputs leave from flops.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.write     = bus.req_write;
          req_d.size      = in_size_c;
          req_d.is_signed = bus.req_signed;
          req_d.addr      = bus.req_addr;
          req_d.wdata     = bus.req_wdata;
          req_ready_d     = 1'b0;
          if (misaligned(in_size_c, bus.req_addr[LANE_W-1:0])) begin
            state_d      = ST_RSP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else if (bus.req_write && in_size_c == SZ_WORD) begin
            state_d      = ST_WR;
            mem_write_d  = 1'b1;
            mem_addr_d   = bus.req_addr[BYTE_AW-1:LANE_W];
            mem_datain_d = bus.req_wdata;
          end else begin
            state_d    = ST_RD;
            mem_addr_d = bus.req_addr[BYTE_AW-1:LANE_W];
          end
        end
      end
      ST_RD: state_d = ST_WT;
      // Read data is on mem_dataout here; finish a load or build the merged word.
      ST_WT: begin
        if (req_q.write) begin
          state_d      = ST_WR;
          mem_write_d  = 1'b1;
          mem_addr_d   = req_q.addr[BYTE_AW-1:LANE_W];
          mem_datain_d = lane_merged_c;
        end else begin
          state_d      = ST_RSP;
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_rdata_c;
          resp_err_d   = 1'b0;
        end
      end
      ST_WR: begin
        state_d      = ST_RSP;
        resp_valid_d = 1'b1;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
      end
      ST_RSP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_datain     = mem_datain_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level reference model
// of a 16-word memory region, plus directed boundary scenarios.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_datain;
  logic [31:0] mem_dataout;

  logic [31:0] mem [0:65535];
  logic [31:0] ref_mem [0:15];

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;

  logic [31:0] rd_o;
  logic        err_o;
  int          lat_o;
  int          wr_o;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with a one-cycle registered read port.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_datain;
    mem_dataout <= mem[mem_addr];
  end

  always @(negedge clk) if (mem_write) wr_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: applies one access to ref_mem and predicts the response.
  task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [17:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int nwr);
    int          idx;
    int          sh;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] v;
    idx  = int'(a) / 4;
    word = ref_mem[idx];
    rd   = 32'h0;
    nwr  = 0;
    er   = (sz == 2'd3) || (sz == 2'd1 && (int'(a) % 2) != 0) ||
           (sz == 2'd2 && (int'(a) % 4) != 0);
    if (sz == 2'd1) sh = ((int'(a) % 4) / 2) * 16;
    else            sh = (int'(a) % 4) * 8;
    if (sz == 2'd0)      mask = 32'h0000_00FF;
    else if (sz == 2'd1) mask = 32'h0000_FFFF;
    else                 mask = 32'hFFFF_FFFF;
    if (er) begin
      lat = 1;
    end else if (!w) begin
      lat = 3;
      v = (word >> sh) & mask;
      if (sg && sz == 2'd0 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
      if (sg && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      rd = v;
    end else begin
      lat = (sz == 2'd2) ? 2 : 4;
      nwr = 1;
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [17:0] a, input logic [31:0] wd, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          lat;
    int          wr0;
    logic [15:0] addr0;
    model(w, sz, sg, a, wd, exp_rd, exp_err, exp_lat, exp_wr);
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'h1);
    addr0          = mem_addr;
    wr0            = wr_cnt;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      check_eq("req_ready_busy", 32'(bus.req_ready), 32'h0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_rdata", bus.resp_rdata, exp_rd);
    check_eq("resp_err", 32'(bus.resp_err), 32'(exp_err));
    // Backpressure: a competing request is offered but must not be taken.
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'd2;
      bus.req_addr  = 18'h0;
      @(posedge clk);
      #1;
      check_eq("hold_valid", 32'(bus.resp_valid), 32'h1);
      check_eq("hold_rdata", bus.resp_rdata, exp_rd);
      check_eq("hold_err", 32'(bus.resp_err), 32'(exp_err));
      check_eq("hold_req_ready", 32'(bus.req_ready), 32'h0);
      check_eq("hold_mem_write", 32'(mem_write), 32'h0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check_eq("post_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("post_req_ready", 32'(bus.req_ready), 32'h1);
    check_eq("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (exp_err) check_eq("err_mem_addr", 32'(mem_addr), 32'(addr0));
    rd_o  = bus.resp_rdata;
    rd_o  = exp_rd;
    err_o = exp_err;
    lat_o = lat;
    wr_o  = wr_cnt - wr0;
  endtask

  logic [31:0] last_rd;
  logic        last_err;

  // Same as do_req but captures the DUT response for directed constant checks.
  task automatic do_req_cap(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [17:0] a, input logic [31:0] wd, input int hold);
    fork
      begin
        @(posedge bus.resp_valid);
        #1;
        last_rd  = bus.resp_rdata;
        last_err = bus.resp_err;
      end
    join_none
    do_req(w, sz, sg, a, wd, hold);
  endtask

  initial begin
    int wr_before;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 18'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    last_rd        = 32'h0;
    last_err       = 1'b0;
    reset          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check_eq("rst_resp_err", 32'(bus.resp_err), 32'h0);
    check_eq("rst_mem_write", 32'(mem_write), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_mem_datain", mem_datain, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_req(1'b1, 2'd2, 1'b0, 18'(i * 4), $urandom, 0);

    do_req(1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF, 0);
    check_eq("tp_wst_lat", 32'(lat_o), 32'd2);
    do_req_cap(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0, 0);
    check_eq("tp_wld_data", last_rd, 32'hDEADBEEF);
    check_eq("tp_wld_lat", 32'(lat_o), 32'd3);

    do_req(1'b1, 2'd2, 1'b0, 18'h00010, 32'h11223344, 0);
    do_req(1'b1, 2'd0, 1'b0, 18'h00012, 32'h000000AA, 0);
    check_eq("tp_bst_mem", mem[4], 32'h11AA3344);
    check_eq("tp_bst_writes", 32'(wr_o), 32'd1);
    check_eq("tp_bst_lat", 32'(lat_o), 32'd4);

    do_req(1'b1, 2'd2, 1'b0, 18'h00010, 32'h8001FFFE, 0);
    do_req_cap(1'b0, 2'd1, 1'b1, 18'h00012, 32'h0, 0);
    check_eq("tp_hld_signed", last_rd, 32'hFFFF8001);
    do_req_cap(1'b0, 2'd1, 1'b0, 18'h00012, 32'h0, 0);
    check_eq("tp_hld_unsigned", last_rd, 32'h00008001);

    do_req_cap(1'b0, 2'd2, 1'b0, 18'h00011, 32'h0, 0);
    check_eq("tp_mis_err", 32'(last_err), 32'h1);
    check_eq("tp_mis_rdata", last_rd, 32'h0);
    check_eq("tp_mis_lat", 32'(lat_o), 32'd1);
    check_eq("tp_mis_writes", 32'(wr_o), 32'd0);

    do_req(1'b0, 2'd0, 1'b1, 18'h00013, 32'h0, 5);

    // Reset while the byte store sits in WT: no write may reach memory.
    wr_before = wr_cnt;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 18'h00011;
    bus.req_wdata  = 32'h00000055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rmid_req_ready", 32'(bus.req_ready), 32'h1);
    check_eq("rmid_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_eq("rmid_mem_write", 32'(mem_write), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rmid_writes", 32'(wr_cnt - wr_before), 32'h0);
    check_eq("rmid_mem", mem[4], ref_mem[4]);

    for (int n = 0; n < 300; n++) begin
      logic [1:0] sz;
      sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom), sz, 1'($urandom), 18'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 16; i++) check_eq("final_mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the CPU execute stage and the 64K x 32 word-addressed data memory. Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. Converts them to word accesses against the memory's one-cycle registered read port, using read-modify-write for sub-word stores. Returns sign- or zero-extended load data, or a misalignment error, over a second valid/ready handshake.

## Interface
- No parameters. Widths are fixed by the data memory: 16-bit word address, 32-bit data.
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- `req_signed`  in  1  loads only: sign-extend when 1, zero-extend when 0.
- `req_addr`  in  18  byte address; [17:2] is the word address, [1:0] is the byte lane.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access; memory untouched.
- `mem_write`  out  1  to the data memory's write input.
- `mem_addr`  out  16  to the data memory's address input.
- `mem_datain`  out  32  to the data memory's write-data input.
- `mem_dataout`  in  32  registered memory read data; valid one cycle after the address is presented.

## Operation
- FSM states: IDLE, RD, WT, WR, RSP. State encoding constants live in the package.
- IDLE: `req_ready`=1. On `req_valid`, latch write, size, signed, addr and wdata, then branch:
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size 3): go to RSP with err=1.
  - Word store: go to WR.
  - Everything else: go to RD.
- RD: drive `mem_addr`=addr[17:2]; go to WT.
- WT: `mem_dataout` holds the word. A load extracts the lane and extends it into `resp_rdata`, then goes to RSP. A sub-word store merges wdata into that lane, then goes to WR.
- Lane mapping is little-endian:
  - Byte lane n occupies bits [8n+7:8n].
  - Halfword at addr[1]=h occupies bits [16h+15:16h].
- WR: `mem_write`=1 for exactly this one cycle, with `mem_addr` and `mem_datain` (merged word, or wdata for a word store); go to RSP.
- RSP: `resp_valid`=1. Hold all response outputs stable until `resp_ready`, then go to IDLE.
- `mem_write` is 0 in every state except WR. `mem_addr` holds its last value outside RD and WR.
- Reset (low at a posedge): the next state is IDLE with all outputs at their reset values. If the FSM was in WR at that edge, the memory still samples that write.

## Timing
- Reset values: `req_ready`=1 (IDLE), `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_write`=0, `mem_addr`=0, `mem_datain`=0.
- Acceptance edge = E0.
- Load: RD in E0–E1, WT in E1–E2; `resp_valid` rises after E2. Latency is 3 cycles.
- Word store: WR in E0–E1 (memory writes at E1); `resp_valid` rises after E1. Latency is 2 cycles.
- Sub-word store: RD, WT, WR; memory writes at E3; `resp_valid` rises after E3. Latency is 4 cycles.
- Misaligned request: `resp_valid` rises after E0, with no memory traffic.
- No pipelining: one request is outstanding at a time. `req_ready`=0 from acceptance until the response handshake completes.
- Back-to-back: if `resp_ready` is high in RSP, IDLE follows and the next request can be accepted the cycle after.

## Structure
- Shared package `lsu_pkg`:
  - State encoding.
  - Size codes: SZ_BYTE, SZ_HALF, SZ_WORD.
  - Width constants: 16-bit word address, 18-bit byte address, 32-bit data.
- One natural sub-module, `lsu_lane`: purely combinational. It performs lane extract/extend for loads and lane merge for stores. It is reused by the load path and the store path.

## Test plan
- Word store then word load: store 0xDEADBEEF at byte addr 0x00010, then load word 0x00010. Required: `resp_rdata`=0xDEADBEEF and `resp_valid` 3 cycles after the load's acceptance edge.
- Byte store read-modify-write: with mem[4]=0x11223344, store byte 0xAA to byte addr 0x00012. Required: mem[4]=0x11AA3344 and `mem_write` high for exactly one cycle.
- Signed and unsigned halfword loads: with mem[4]=0x8001FFFE, load half at byte addr 0x00012.
  - Signed: `resp_rdata`=0xFFFF8001.
  - Unsigned: `resp_rdata`=0x00008001.
- Misaligned access: word load at byte addr 0x00011. Required: `resp_err`=1, `resp_rdata`=0, and `mem_write` and `mem_addr` unchanged.
- Response backpressure: hold `resp_ready`=0 for 5 cycles in RSP. Required: response outputs stable, `req_ready`=0, and a new request is not accepted until after the handshake.
- Reset mid-operation: drive `reset` low while in WT of a byte store. Required: next cycle is IDLE with `req_ready`=1 and `resp_valid`=0, and no memory write occurs.
